stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Egress side of the QoS stream arbiter: takes the single arbitrated stream and routes each packet back to one of STREAM_COUNT output streams by destination index.
- Uses the same index encoding as the arbiter tree. The value STREAM_COUNT means "no stream".
- One registered pipeline stage. Packet-atomic routing: the destination is locked from the first beat until the TLAST beat.

Parameters:
- T_DATA_WIDTH, 8, payload width per beat
- T_QOS__WIDTH, 4, QoS field width, carried through unchanged
- STREAM_COUNT, 2, number of output streams (>=2)
- IDX_W, $clog2(STREAM_COUNT)+1, destination index width (localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-high (asserted = 1)
- s_data_i  in  T_DATA_WIDTH  input payload
- s_qos_i  in  T_QOS__WIDTH  input QoS
- s_dest_i  in  IDX_W  destination index; sampled on the first beat only
- s_last_i  in  1  last beat of packet
- s_valid_i  in  1  input valid
- s_ready_o  out  1  input ready
- m_data_o  out  [STREAM_COUNT] x T_DATA_WIDTH  per-stream payload
- m_qos_o  out  [STREAM_COUNT] x T_QOS__WIDTH  per-stream QoS
- m_last_o  out  [STREAM_COUNT]  per-stream last
- m_valid_o  out  [STREAM_COUNT]  per-stream valid; at most one bit set (one-hot or zero)
- m_ready_i  in  [STREAM_COUNT]  per-stream ready

Behaviour:
- Handshake: a transfer occurs when valid && ready at the clk edge. Once valid is asserted it holds until the transfer, with data stable.
- Reset (rst_n=1 at clk edge):
  - FSM to IDLE, stage register empty, locked dest = STREAM_COUNT.
  - Registered outputs cleared: m_valid_o=0, m_data_o/m_qos_o/m_last_o = 0.
  - s_ready_o=0 while rst_n=1.
  - Any beat in flight is discarded; a partial packet is not completed.
- Stage register: holds one beat plus its locked dest.
  - s_ready_o = !stage_valid || (m_ready_i[stage_dest] && state!=DROP) || state==DROP.
  - Full throughput of 1 beat/clk when the selected output is ready. Latency: accept at edge N, m_valid_o visible after edge N.
  - m_valid_o[stage_dest] = stage_valid. Other valid bits are 0. The payload of non-selected streams is 0.
- FSM states:
  - IDLE: no packet open. On an accepted beat with s_dest_i < STREAM_COUNT, lock dest and load the stage. If s_last_i=1 stay IDLE, else go to ROUTE. On an accepted beat with s_dest_i >= STREAM_COUNT, go to DROP (stay IDLE if s_last_i=1); the beat is discarded.
  - ROUTE: beats go to the locked dest and s_dest_i is ignored. An accepted beat with s_last_i=1 returns to IDLE.
  - DROP: s_ready_o=1 and beats are discarded (the stage is not loaded). An accepted s_last_i beat returns to IDLE.
- Back-to-back packets:
  - A new packet's first beat may be accepted in the same cycle the previous packet's last beat leaves the stage.
  - The new dest is taken from the new beat, even if it differs from the old one.
- Backpressure: while m_ready_i[dest]=0 and the stage is full, s_ready_o=0. Ready bits of other streams have no effect.
- Out-of-range dest: any dest value from STREAM_COUNT up to 2^IDX_W-1 is treated as the "none" index and dropped.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o [15:0], a saturating count of dropped packets.
  - Increments by 1 when a dropped packet's first beat is accepted; holds at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; drop behaviour is otherwise identical.

Decomposition:
- Shared package stream_arb_pkg:
  - idx_w(STREAM_COUNT) function
  - NONE_IDX constant (=STREAM_COUNT)
  - demux_state_t enum {IDLE, ROUTE, DROP}
  - beat struct {data, qos, last}
- One sub-module, stream_demux_stage: a one-entry register slice with load/drain controls and a dest field. The top level holds the FSM, lock logic and output fan-out.

Test Plan:
- Reset mid-packet: 3-beat packet to dest 1, assert rst_n after beat 2 → m_valid_o=0 next cycle, FSM IDLE. The next packet to dest 0 routes correctly.
- Single-beat packets alternating dest 0,1,0 with all m_ready_i=1 → one beat/clk out, m_valid_o = 01,10,01, latency 1 clk, data/qos match.
- 4-beat packet to dest 1 with s_dest_i changed to 0 on beats 2-4 → all 4 beats appear on stream 1 only; m_last_o[1]=1 on beat 4 only.
- Backpressure: m_ready_i[1]=0 for 5 clks during a packet to dest 1, m_ready_i[0]=1 → s_ready_o=0 while the stage is full, beat held stable, no loss or duplication after release.
- Dest = STREAM_COUNT (2), 3-beat packet → s_ready_o=1 throughout, m_valid_o=0. With the macro defined, drop_cnt_o goes 0→1; preset near saturation, it holds at FFFF.
- Last beat of a dest-0 packet and first beat of a dest-1 packet on consecutive clks with ready=1 → no bubble, dest switches cleanly.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared definitions for the QoS stream arbiter tree and its egress demux.
package stream_arb_pkg;

  // Destination index width: one extra bit so STREAM_COUNT ("no stream") is encodable.
  function automatic int idx_w(input int stream_count);
    return $clog2(stream_count) + 1;
  endfunction

  // The "no stream" index equals the stream count.
  function automatic int none_idx(input int stream_count);
    return stream_count;
  endfunction

  localparam int NONE_IDX = none_idx(2);

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } demux_state_t;

  localparam int BEAT_DATA_W = 8;
  localparam int BEAT_QOS_W  = 4;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_QOS_W-1:0]  qos;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/stream_demux_stage.sv
// One-entry register slice holding a beat and the destination it is routed to.
module stream_demux_stage #(
  parameter int W        = 13,
  parameter int IDX_W    = 2,
  parameter int NONE_VAL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [IDX_W-1:0] load_dest,
  input  logic [W-1:0]     load_beat,
  output logic             stage_valid,
  output logic [IDX_W-1:0] stage_dest,
  output logic [W-1:0]     stage_beat
);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stage_valid <= 1'b0;
      stage_dest  <= IDX_W'(NONE_VAL);
      stage_beat  <= '0;
    end else if (load) begin
      stage_valid <= 1'b1;
      stage_dest  <= load_dest;
      stage_beat  <= load_beat;
    end else if (drain) begin
      stage_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Egress demux: routes whole packets from the arbitrated stream to one of STREAM_COUNT outputs.
// Optional macro STREAM_DEMUX_DROP_CNT_EN adds a saturating dropped-packet counter (drop_cnt_o).
module stream_demux
  import stream_arb_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  localparam int IDX_W       = idx_w(STREAM_COUNT)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [T_DATA_WIDTH-1:0]                  s_data_i,
  input  logic [T_QOS__WIDTH-1:0]                  s_qos_i,
  input  logic [IDX_W-1:0]                         s_dest_i,
  input  logic                                     s_last_i,
  input  logic                                     s_valid_i,
  output logic                                     s_ready_o,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_o,
  output logic [STREAM_COUNT-1:0]                  m_last_o,
  output logic [STREAM_COUNT-1:0]                  m_valid_o,
  input  logic [STREAM_COUNT-1:0]                  m_ready_i
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]                              drop_cnt_o
`endif
);

  localparam int BEAT_W = T_DATA_WIDTH + T_QOS__WIDTH + 1;
  localparam logic [IDX_W-1:0] NONE = IDX_W'(none_idx(STREAM_COUNT));

  demux_state_t state, next_state;
  logic [IDX_W-1:0] lock_dest;
  logic             lock_en;
  logic             load;
  logic [IDX_W-1:0] load_dest;
  logic             drop_first;
  logic             accept;
  logic             in_range;

  logic              stage_valid;
  logic [IDX_W-1:0]  stage_dest;
  logic [BEAT_W-1:0] stage_beat;
  logic [STREAM_COUNT-1:0] dest_hit;
  logic              sel_ready;
  logic              drain;

  always_comb begin
    dest_hit = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      dest_hit[i] = (stage_dest == IDX_W'(i));
    end
  end

  assign sel_ready = |(m_ready_i & dest_hit);
  assign drain     = stage_valid && sel_ready;
  assign in_range  = (s_dest_i < NONE);
  // DROP discards beats, so it never waits on the stage.
  assign s_ready_o = !rst_n && (!stage_valid || sel_ready || state == DROP);
  assign accept    = s_valid_i && s_ready_o;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      lock_dest <= NONE;
    end else begin
      state <= next_state;
      if (lock_en) lock_dest <= s_dest_i;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_dest  = lock_dest;
    lock_en    = 1'b0;
    drop_first = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_range) begin
            load      = 1'b1;
            load_dest = s_dest_i;
            lock_en   = 1'b1;
            if (!s_last_i) next_state = ROUTE;
          end else begin
            drop_first = 1'b1;
            if (!s_last_i) next_state = DROP;
          end
        end
      end
      ROUTE: begin
        if (accept) begin
          load = 1'b1;
          if (s_last_i) next_state = IDLE;
        end
      end
      DROP: begin
        if (accept && s_last_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  stream_demux_stage #(
    .W        (BEAT_W),
    .IDX_W    (IDX_W),
    .NONE_VAL (STREAM_COUNT)
  ) u_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .drain       (drain),
    .load_dest   (load_dest),
    .load_beat   ({s_data_i, s_qos_i, s_last_i}),
    .stage_valid (stage_valid),
    .stage_dest  (stage_dest),
    .stage_beat  (stage_beat)
  );

  // Non-selected streams see an all-zero payload.
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      m_valid_o[i] = stage_valid && dest_hit[i];
      m_data_o[i]  = m_valid_o[i] ? stage_beat[BEAT_W-1 -: T_DATA_WIDTH] : '0;
      m_qos_o[i]   = m_valid_o[i] ? stage_beat[T_QOS__WIDTH:1] : '0;
      m_last_o[i]  = m_valid_o[i] && stage_beat[0];
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      drop_cnt_o <= '0;
    end else if (drop_first && drop_cnt_o != 16'hFFFF) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with STREAM_COUNT=2 (dest index width 2).
module tb_stream_demux;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      s_data_i;
  logic [3:0]      s_qos_i;
  logic [1:0]      s_dest_i;
  logic            s_last_i;
  logic            s_valid_i;
  logic            s_ready_o;
  logic [1:0][7:0] m_data_o;
  logic [1:0][3:0] m_qos_o;
  logic [1:0]      m_last_o;
  logic [1:0]      m_valid_o;
  logic [1:0]      m_ready_i;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0]     drop_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_qos_i   (s_qos_i),
    .s_dest_i  (s_dest_i),
    .s_last_i  (s_last_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_qos_o   (m_qos_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt_o(drop_cnt_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] dat,
                       input logic [3:0] q, input logic l);
    s_valid_i = v;
    s_dest_i  = d;
    s_data_i  = dat;
    s_qos_i   = q;
    s_last_i  = l;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    m_ready_i = 2'b11;
    drive(1'b1, 2'd0, 8'hEE, 4'hE, 1'b1);
    repeat (3) step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", m_valid_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", s_ready_o); end
    checks++; if (m_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", m_data_o); end
    checks++; if (m_last_o !== 2'b00) begin errors++; $display("FAIL reset_last: got %b expected 00", m_last_o); end
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", s_ready_o); end
  endtask

  task automatic test_reset_mid_packet();
    drive(1'b1, 2'd1, 8'h11, 4'h1, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b10 || m_data_o[1] !== 8'h11) begin errors++; $display("FAIL mid_beat1: valid %b data %h expected 10 11", m_valid_o, m_data_o[1]); end
    drive(1'b1, 2'd1, 8'h12, 4'h1, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b10 || m_data_o[1] !== 8'h12) begin errors++; $display("FAIL mid_beat2: valid %b data %h expected 10 12", m_valid_o, m_data_o[1]); end
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL mid_reset_valid: got %b expected 00", m_valid_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", s_ready_o); end
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 8'h21, 4'h2, 1'b1);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL mid_after_ready: got %b expected 1", s_ready_o); end
    step();
    checks++; if (m_valid_o !== 2'b01) begin errors++; $display("FAIL mid_after_valid: got %b expected 01", m_valid_o); end
    checks++; if (m_data_o[0] !== 8'h21 || m_qos_o[0] !== 4'h2 || m_last_o !== 2'b01) begin errors++; $display("FAIL mid_after_payload: data %h qos %h last %b expected 21 2 01", m_data_o[0], m_qos_o[0], m_last_o); end
    checks++; if (m_data_o[1] !== 8'h00) begin errors++; $display("FAIL mid_after_other: got %h expected 00", m_data_o[1]); end
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL mid_after_empty: got %b expected 00", m_valid_o); end
  endtask

  task automatic test_alternate();
    logic [1:0] dests [3] = '{2'd0, 2'd1, 2'd0};
    logic [7:0] datas [3] = '{8'hA1, 8'hB2, 8'hC3};
    logic [3:0] qoss  [3] = '{4'h3, 4'h5, 4'h7};
    logic [1:0] exp_valid;
    m_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, dests[i], datas[i], qoss[i], 1'b1);
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL alt_ready[%0d]: got %b expected 1", i, s_ready_o); end
      step();
      exp_valid = (dests[i] == 2'd0) ? 2'b01 : 2'b10;
      checks++; if (m_valid_o !== exp_valid) begin errors++; $display("FAIL alt_valid[%0d]: got %b expected %b", i, m_valid_o, exp_valid); end
      checks++; if (m_data_o[dests[i]] !== datas[i] || m_qos_o[dests[i]] !== qoss[i] || m_last_o !== exp_valid) begin errors++; $display("FAIL alt_payload[%0d]: data %h qos %h last %b expected %h %h %b", i, m_data_o[dests[i]], m_qos_o[dests[i]], m_last_o, datas[i], qoss[i], exp_valid); end
    end
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL alt_drain: got %b expected 00", m_valid_o); end
  endtask

  task automatic test_dest_lock();
    logic [1:0] exp_last;
    m_ready_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 2'd1 : 2'd0, 8'h40 + 8'(i), 4'h9, i == 3);
      step();
      exp_last = (i == 3) ? 2'b10 : 2'b00;
      checks++; if (m_valid_o !== 2'b10 || m_data_o[1] !== 8'h40 + 8'(i)) begin errors++; $display("FAIL lock_beat[%0d]: valid %b data %h expected 10 %h", i, m_valid_o, m_data_o[1], 8'h40 + 8'(i)); end
      checks++; if (m_last_o !== exp_last || m_data_o[0] !== 8'h00) begin errors++; $display("FAIL lock_last[%0d]: last %b other %h expected %b 00", i, m_last_o, m_data_o[0], exp_last); end
    end
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL lock_drain: got %b expected 00", m_valid_o); end
  endtask

  task automatic test_backpressure();
    m_ready_i = 2'b01;
    drive(1'b1, 2'd1, 8'h50, 4'h4, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b10 || m_data_o[1] !== 8'h50) begin errors++; $display("FAIL bp_first: valid %b data %h expected 10 50", m_valid_o, m_data_o[1]); end
    drive(1'b1, 2'd1, 8'h51, 4'h4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, s_ready_o); end
      checks++; if (m_valid_o !== 2'b10 || m_data_o[1] !== 8'h50) begin errors++; $display("FAIL bp_hold[%0d]: valid %b data %h expected 10 50", i, m_valid_o, m_data_o[1]); end
      step();
    end
    m_ready_i = 2'b11;
    #1;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", s_ready_o); end
    step();
    checks++; if (m_valid_o !== 2'b10 || m_data_o[1] !== 8'h51) begin errors++; $display("FAIL bp_second: valid %b data %h expected 10 51", m_valid_o, m_data_o[1]); end
    drive(1'b1, 2'd1, 8'h52, 4'h4, 1'b1);
    step();
    checks++; if (m_data_o[1] !== 8'h52 || m_last_o !== 2'b10) begin errors++; $display("FAIL bp_third: data %h last %b expected 52 10", m_data_o[1], m_last_o); end
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL bp_drain: got %b expected 00", m_valid_o); end
  endtask

  task automatic test_drop();
    m_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd2, 8'h60 + 8'(i), 4'h6, i == 2);
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL drop_ready[%0d]: got %b expected 1", i, s_ready_o); end
      step();
      checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL drop_valid[%0d]: got %b expected 00", i, m_valid_o); end
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    checks++; if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL drop_cnt_1: got %0d expected 1", drop_cnt_o); end
`endif
    drive(1'b1, 2'd3, 8'h65, 4'h6, 1'b1);
    step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL drop_idx3_valid: got %b expected 00", m_valid_o); end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL drop_cnt_2: got %0d expected 2", drop_cnt_o); end
`endif
    drive(1'b1, 2'd1, 8'h66, 4'h6, 1'b1);
    step();
    checks++; if (m_valid_o !== 2'b10 || m_data_o[1] !== 8'h66) begin errors++; $display("FAIL drop_recover: valid %b data %h expected 10 66", m_valid_o, m_data_o[1]); end
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] dests [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    logic [7:0] datas [4] = '{8'h70, 8'h71, 8'h72, 8'h73};
    logic       lasts [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_valid;
    m_ready_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, dests[i], datas[i], 4'hB, lasts[i]);
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, s_ready_o); end
      step();
      exp_valid = (dests[i] == 2'd0) ? 2'b01 : 2'b10;
      checks++; if (m_valid_o !== exp_valid || m_data_o[dests[i]] !== datas[i]) begin errors++; $display("FAIL b2b_beat[%0d]: valid %b data %h expected %b %h", i, m_valid_o, m_data_o[dests[i]], exp_valid, datas[i]); end
      checks++; if (m_last_o !== (lasts[i] ? exp_valid : 2'b00)) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, m_last_o, lasts[i] ? exp_valid : 2'b00); end
    end
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
    checks++; if (m_valid_o !== 2'b00) begin errors++; $display("FAIL b2b_drain: got %b expected 00", m_valid_o); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_packet();
    test_alternate();
    test_dest_lock();
    test_backpressure();
    test_drop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
